regfile_writeback: RTL and testbench

- Write-side front end for the 32x32 register file. It merges single-cycle ALU results with variable-latency load results onto the file's single write port (rd / write_data / mem_write).
- Load results are buffered in a small FIFO. A starvation counter guarantees loads drain.
- Hazard flags let decode stall on registers that still have a pending write.

---
 rtl/regfile_writeback.sv | 146 ++++++++++++++
 tb/tb_regfile_writeback.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file. ALU results and buffered
// load results share the single registered write port. A starvation counter
// makes sure loads drain, and hazard flags report registers with pending writes.
module regfile_writeback #(
  parameter int unsigned N            = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter bit          DROP_X0      = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [4:0]               alu_rd_i,
  input  logic [N-1:0]             alu_data_i,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [4:0]               ld_rd_i,
  input  logic [N-1:0]             ld_data_i,
  input  logic [4:0]               query_rs1_i,
  input  logic [4:0]               query_rs2_i,
  output logic                     hazard_rs1_o,
  output logic                     hazard_rs2_o,
  output logic [4:0]               rd_o,
  output logic [N-1:0]             write_data_o,
  output logic                     mem_write_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [StW-1:0]  StLimit = StW'(STARVE_LIMIT);

  // Load FIFO storage and control
  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [N-1:0]    fifo_data_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;

  // Output stage
  logic [4:0]   rd_q, rd_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         mem_write_q, mem_write_d;

  logic             fifo_empty, fifo_full, starved;
  logic             push, pop, grant_ld, alu_xfer, win;
  logic [4:0]       win_rd;
  logic [N-1:0]     win_data;
  logic [DEPTH-1:0] entry_valid;

  // Handshakes and arbitration between the ALU and the FIFO head
  always_comb begin
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CntFull);
    starved     = !fifo_empty && (starve_q == StLimit);
    ld_ready_o  = !rst_i && !fifo_full;
    alu_ready_o = !rst_i && !starved;
    push        = ld_valid_i && ld_ready_o;
    grant_ld    = !rst_i && !fifo_empty && (!alu_valid_i || starve_q == StLimit);
    alu_xfer    = alu_valid_i && alu_ready_o;
    pop         = grant_ld;
    win         = grant_ld || alu_xfer;
    win_rd      = grant_ld ? fifo_rd_q[rd_ptr_q]   : alu_rd_i;
    win_data    = grant_ld ? fifo_data_q[rd_ptr_q] : alu_data_i;
  end

  // Next-state for occupancy, starvation counter and the write port
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (fifo_empty || grant_ld) begin
      starve_d = '0;
    end else if (alu_xfer && starve_q != StLimit) begin
      starve_d = starve_q + StW'(1);
    end

    // A dropped x0 write still consumes its source; only the enable is suppressed
    rd_d        = win ? win_rd : rd_q;
    wdata_d     = win ? win_data : wdata_q;
    mem_write_d = win && !(DROP_X0 && win_rd == 5'd0);
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      rd_q        <= '0;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_d;
      starve_q    <= starve_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
    end
  end

  // FIFO payload storage; contents are meaningless outside the occupied window
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ld_rd_i;
      fifo_data_q[wr_ptr_q] <= ld_data_i;
    end
  end

  // An entry is live when its distance from the head is below the occupancy
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PtrW'(i) - rd_ptr_q} < count_q);
    end
  end

  // Hazard flags: live FIFO entries plus the write currently at the port
  always_comb begin
    hazard_rs1_o = mem_write_q && (rd_q == query_rs1_i);
    hazard_rs2_o = mem_write_q && (rd_q == query_rs2_i);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && fifo_rd_q[i] == query_rs1_i) hazard_rs1_o = 1'b1;
      if (entry_valid[i] && fifo_rd_q[i] == query_rs2_i) hazard_rs2_o = 1'b1;
    end
    if (DROP_X0 && query_rs1_i == 5'd0) hazard_rs1_o = 1'b0;
    if (DROP_X0 && query_rs2_i == 5'd0) hazard_rs2_o = 1'b0;
  end

  assign rd_o         = rd_q;
  assign write_data_o = wdata_q;
  assign mem_write_o  = mem_write_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU path, load path,
// backpressure with starvation, FIFO wrap ordering, x0 drop and mid-flight reset.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  q1, q2;
  logic        haz1, haz2;
  logic [4:0]  rd;
  logic [31:0] wd;
  logic        mem_write;
  logic [2:0]  fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf_q [32];

  always #5 clk = ~clk;

  regfile_writeback #(
    .N(32), .DEPTH(4), .STARVE_LIMIT(3), .DROP_X0(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alu_valid_i  (alu_valid),
    .alu_ready_o  (alu_ready),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .ld_valid_i   (ld_valid),
    .ld_ready_o   (ld_ready),
    .ld_rd_i      (ld_rd),
    .ld_data_i    (ld_data),
    .query_rs1_i  (q1),
    .query_rs2_i  (q2),
    .hazard_rs1_o (haz1),
    .hazard_rs2_o (haz2),
    .rd_o         (rd),
    .write_data_o (wd),
    .mem_write_o  (mem_write),
    .fifo_count_o (fifo_count)
  );

  // Register file model fed by the write port
  always @(posedge clk) begin
    if (mem_write) rf_q[rd] <= wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Advance to just after the next active edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n_ld, exp_rd, max_cnt;
    logic acc;

    // Reset held two cycles with both sources valid
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h22; q1 = 5'd0; q2 = 5'd0;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      check_eq("rst_alu_ready", alu_ready, 0);
      check_eq("rst_ld_ready", ld_ready, 0);
      check_eq("rst_mem_write", mem_write, 0);
      check_eq("rst_count", fifo_count, 0);
    end
    rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    step(); #1;
    check_eq("post_rst_mem_write", mem_write, 0);
    check_eq("post_rst_count", fifo_count, 0);

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; #1;
    check_eq("alu_ready", alu_ready, 1);
    step(); alu_valid = 1'b0; #1;
    check_eq("alu_wr_en", mem_write, 1);
    check_eq("alu_wr_rd", rd, 5);
    check_eq("alu_wr_data", wd, 32'hDEADBEEF);
    step(); #1;
    check_eq("alu_wr_once", mem_write, 0);
    check_eq("alu_rd_hold", rd, 5);
    step(); #1;
    check_eq("rf_read_5", rf_q[5], 32'hDEADBEEF);

    // Load only into empty FIFO
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h1234; q1 = 5'd7; #1;
    check_eq("ld_ready", ld_ready, 1);
    check_eq("ld_haz_k", haz1, 0);
    step(); ld_valid = 1'b0; #1;
    check_eq("ld_count_k1", fifo_count, 1);
    check_eq("ld_haz_k1", haz1, 1);
    check_eq("ld_no_wr_k1", mem_write, 0);
    step(); #1;
    check_eq("ld_wr_en_k2", mem_write, 1);
    check_eq("ld_wr_rd_k2", rd, 7);
    check_eq("ld_wr_data_k2", wd, 32'h1234);
    check_eq("ld_haz_k2", haz1, 1);
    check_eq("ld_count_k2", fifo_count, 0);
    step(); #1;
    check_eq("ld_haz_k3", haz1, 0);
    check_eq("ld_wr_once", mem_write, 0);

    // Fill and backpressure with ALU continuously valid
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA0;
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'h1100;
    step(); ld_rd = 5'd12; ld_data = 32'h1200; #1;
    check_eq("fill_alu_wr_en", mem_write, 1);
    check_eq("fill_alu_wr_rd", rd, 9);
    step(); ld_rd = 5'd13; ld_data = 32'h1300;
    step(); ld_rd = 5'd14; ld_data = 32'h1400; #1;
    check_eq("fill_count3", fifo_count, 3);
    check_eq("fill_alu_ready3", alu_ready, 1);
    step(); ld_rd = 5'd15; ld_data = 32'h1500; #1;
    check_eq("fill_count4", fifo_count, 4);
    check_eq("fill_ld_ready_full", ld_ready, 0);
    check_eq("fill_alu_blocked", alu_ready, 0);
    step(); ld_valid = 1'b0; alu_valid = 1'b0; #1;
    check_eq("fill_head_wr_en", mem_write, 1);
    check_eq("fill_head_rd", rd, 11);
    check_eq("fill_head_data", wd, 32'h1100);
    check_eq("fill_ld_ready_rise", ld_ready, 1);
    check_eq("fill_alu_ready_back", alu_ready, 1);
    check_eq("fill_count_after_pop", fifo_count, 3);
    step(); #1;
    check_eq("drain_rd12", rd, 12);
    step(); #1;
    check_eq("drain_rd13", rd, 13);
    step(); #1;
    check_eq("drain_rd14", rd, 14);
    check_eq("drain_wr14", mem_write, 1);
    check_eq("drain_count0", fifo_count, 0);
    step(); #1;
    check_eq("drain_no_rd15", mem_write, 0);

    // Wrap-around: ten loads with intermittent ALU traffic to rd 20
    n_ld = 1; exp_rd = 1; max_cnt = 0;
    for (int c = 0; c < 300 && exp_rd <= 10; c++) begin
      ld_valid  = (n_ld <= 10);
      ld_rd     = 5'(n_ld);
      ld_data   = 32'(n_ld) * 32'h100;
      alu_valid = (c % 3) != 0;
      alu_rd    = 5'd20;
      alu_data  = 32'(c);
      #1;
      acc = ld_valid && ld_ready;
      if (mem_write && rd != 5'd20) begin
        check_eq("wrap_rd", rd, exp_rd);
        check_eq("wrap_data", wd, exp_rd * 32'h100);
        exp_rd++;
      end
      if (fifo_count > max_cnt) max_cnt = fifo_count;
      step();
      if (acc) n_ld++;
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    check_eq("wrap_all_seen", exp_rd, 11);
    check_eq("wrap_max_count_ok", max_cnt <= 4, 1);

    // x0 drop
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55; #1;
    check_eq("x0_alu_ready", alu_ready, 1);
    step(); alu_valid = 1'b0; #1;
    check_eq("x0_no_write", mem_write, 0);

    // Three loads buffered (one to x0) behind ALU traffic, then reset
    alu_valid = 1'b1; alu_rd = 5'd24; alu_data = 32'h77;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hAA; q1 = 5'd22; q2 = 5'd0;
    step(); ld_rd = 5'd22; ld_data = 32'hBB;
    step(); ld_rd = 5'd23; ld_data = 32'hCC;
    step(); ld_valid = 1'b0; alu_valid = 1'b0; rst = 1'b1; #1;
    check_eq("mid_count3", fifo_count, 3);
    check_eq("mid_haz_rs1", haz1, 1);
    check_eq("mid_haz_x0", haz2, 0);
    check_eq("mid_rst_alu_ready", alu_ready, 0);
    check_eq("mid_rst_ld_ready", ld_ready, 0);
    step(); rst = 1'b0; #1;
    check_eq("mid_count0", fifo_count, 0);
    check_eq("mid_no_write", mem_write, 0);
    check_eq("mid_haz_cleared", haz1, 0);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      check_eq("mid_never_write", mem_write, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
